// File: rtl/ervp_sram_cell_bank.sv
// Single-port SRAM cell bank with bit-masked writes and held, registered read data.
// Define ERVP_SRAM_CELL_BANK_INIT_EN to add the power-up zero-fill sweep.
module ervp_sram_cell_bank #(
    parameter int unsigned BW_DATA       = 16,
    parameter int unsigned BW_CELL_INDEX = 14,
    parameter int unsigned CELL_DEPTH    = 16384
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cell_select,
    input  logic [BW_CELL_INDEX-1:0] cell_index,
    input  logic                     cell_enable,
    input  logic                     cell_write_enable,
    input  logic [BW_DATA-1:0]       cell_write_enable_bit,
    input  logic [BW_DATA-1:0]       cell_wdata,
    input  logic                     cell_read_enable,
    output logic [BW_DATA-1:0]       cell_rdata,
    output logic                     init_busy,
    output logic                     init_done
);

    localparam int unsigned PTR_W  = BW_CELL_INDEX + 1;
    localparam int unsigned ADDR_W = (CELL_DEPTH > 1) ? $clog2(CELL_DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(CELL_DEPTH);

    logic [BW_DATA-1:0] mem_q [CELL_DEPTH];
    logic [BW_DATA-1:0] rdata_q, rdata_d;

    logic               in_range_c;
    logic               access_c;
    logic [ADDR_W-1:0]  idx_c;
    logic [BW_DATA-1:0] merged_c;
    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic [BW_DATA-1:0] mem_wdata_c;

    assign in_range_c = {1'b0, cell_index} < DEPTH_P;
    assign access_c   = cell_select & cell_enable;
    assign idx_c      = cell_index[ADDR_W-1:0];
    assign merged_c   = (mem_q[idx_c] & ~cell_write_enable_bit)
                      | (cell_wdata & cell_write_enable_bit);

`ifdef ERVP_SRAM_CELL_BANK_INIT_EN
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [PTR_W-1:0] LAST_P = PTR_W'(CELL_DEPTH - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // State and sweep pointer; reset always restarts the sweep from index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign init_busy = (state_q == ST_INIT);
    assign init_done = ~init_busy;
`else
    assign init_busy = 1'b0;
    assign init_done = 1'b1;
`endif

    // Next-state: sweep writes zeros; READY serves writes first, reads only without a write.
    always_comb begin
        rdata_d     = rdata_q;
        mem_we_c    = 1'b0;
        mem_addr_c  = idx_c;
        mem_wdata_c = merged_c;
`ifdef ERVP_SRAM_CELL_BANK_INIT_EN
        state_d     = state_q;
        ptr_d       = ptr_q;
        if (state_q == ST_INIT) begin
            mem_we_c    = 1'b1;
            mem_addr_c  = ptr_q[ADDR_W-1:0];
            mem_wdata_c = '0;
            ptr_d       = ptr_q + PTR_W'(1);
            if (ptr_q == LAST_P) begin
                state_d = ST_READY;
            end
        end else
`endif
        if (access_c) begin
            if (cell_write_enable) begin
                mem_we_c = in_range_c;
            end else if (cell_read_enable) begin
                rdata_d = in_range_c ? mem_q[idx_c] : '0;
            end
        end
    end

    // Read data register: changes only on a read or on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem_q[mem_addr_c] <= mem_wdata_c;
        end
    end

    assign cell_rdata = rdata_q;

endmodule

// File: tb/tb_ervp_sram_cell_bank.sv
// Directed self-checking bench for ervp_sram_cell_bank (16-word bank).
module tb_ervp_sram_cell_bank;

    logic        clk;
    logic        rst;
    logic        cell_select;
    logic [4:0]  cell_index;
    logic        cell_enable;
    logic        cell_write_enable;
    logic [15:0] cell_write_enable_bit;
    logic [15:0] cell_wdata;
    logic        cell_read_enable;
    logic [15:0] cell_rdata;
    logic        init_busy;
    logic        init_done;

    int checks;
    int errors;

    ervp_sram_cell_bank #(
        .BW_DATA      (16),
        .BW_CELL_INDEX(5),
        .CELL_DEPTH   (16)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cell_select          (cell_select),
        .cell_index           (cell_index),
        .cell_enable          (cell_enable),
        .cell_write_enable    (cell_write_enable),
        .cell_write_enable_bit(cell_write_enable_bit),
        .cell_wdata           (cell_wdata),
        .cell_read_enable     (cell_read_enable),
        .cell_rdata           (cell_rdata),
        .init_busy            (init_busy),
        .init_done            (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cell_select           = 1'b0;
        cell_enable           = 1'b0;
        cell_write_enable     = 1'b0;
        cell_read_enable      = 1'b0;
        cell_write_enable_bit = 16'h0000;
        cell_wdata            = 16'h0000;
        cell_index            = 5'd0;
    endtask

    task automatic do_write(input logic [4:0] i, input logic [15:0] d, input logic [15:0] m);
        cell_select           = 1'b1;
        cell_enable           = 1'b1;
        cell_write_enable     = 1'b1;
        cell_read_enable      = 1'b0;
        cell_index            = i;
        cell_wdata            = d;
        cell_write_enable_bit = m;
        cyc();
        idle();
    endtask

    task automatic do_read(input logic [4:0] i);
        cell_select       = 1'b1;
        cell_enable       = 1'b1;
        cell_write_enable = 1'b0;
        cell_read_enable  = 1'b1;
        cell_index        = i;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0000", cell_rdata);
        end
`ifdef ERVP_SRAM_CELL_BANK_INIT_EN
        checks++;
        if (init_busy !== 1'b1 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got busy=%b done=%b expected busy=1 done=0", init_busy, init_done);
        end
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL sweep_length: got %0d cycles expected 16", n);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(5'(i));
            checks++;
            if (cell_rdata !== 16'h0000) begin
                errors++;
                $display("FAIL sweep_zero[%0d]: got %h expected 0000", i, cell_rdata);
            end
        end
`else
        checks++;
        if (init_busy !== 1'b0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got busy=%b done=%b expected busy=0 done=1", init_busy, init_done);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (init_busy !== 1'b0 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL first_cycle_done: got busy=%b done=%b expected busy=0 done=1", init_busy, init_done);
        end
        n = 0;
`endif
    endtask

    task automatic test_masked_write();
        do_write(5'd5, 16'hFFFF, 16'hFFFF);
        do_write(5'd5, 16'h1234, 16'h00FF);
        do_read(5'd5);
        checks++;
        if (cell_rdata !== 16'hFF34) begin
            errors++;
            $display("FAIL masked_write: got %h expected ff34", cell_rdata);
        end
        do_write(5'd5, 16'h0000, 16'h0000);
        do_read(5'd5);
        checks++;
        if (cell_rdata !== 16'hFF34) begin
            errors++;
            $display("FAIL zero_mask: got %h expected ff34", cell_rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_write(5'd2, 16'hA5A5, 16'hFFFF);
        do_write(5'd3, 16'h5A5A, 16'hFFFF);
        cell_select      = 1'b1;
        cell_enable      = 1'b1;
        cell_read_enable = 1'b1;
        cell_index       = 5'd2;
        cyc();
        checks++;
        if (cell_rdata !== 16'hA5A5) begin
            errors++;
            $display("FAIL b2b_first: got %h expected a5a5", cell_rdata);
        end
        cell_index = 5'd3;
        cyc();
        checks++;
        if (cell_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL b2b_second: got %h expected 5a5a", cell_rdata);
        end
        idle();
        repeat (10) cyc();
        checks++;
        if (cell_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL hold_idle: got %h expected 5a5a", cell_rdata);
        end
        do_write(5'd3, 16'h0000, 16'hFFFF);
        checks++;
        if (cell_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL hold_write: got %h expected 5a5a", cell_rdata);
        end
        do_read(5'd3);
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reread_3: got %h expected 0000", cell_rdata);
        end
    endtask

    task automatic test_gating();
        do_write(5'd6, 16'h6666, 16'hFFFF);
        do_read(5'd6);
        checks++;
        if (cell_rdata !== 16'h6666) begin
            errors++;
            $display("FAIL gate_setup: got %h expected 6666", cell_rdata);
        end
        cell_select = 1'b0; cell_enable = 1'b1; cell_read_enable = 1'b1; cell_index = 5'd5;
        cyc();
        idle();
        checks++;
        if (cell_rdata !== 16'h6666) begin
            errors++;
            $display("FAIL gate_read_nosel: got %h expected 6666", cell_rdata);
        end
        cell_select = 1'b1; cell_enable = 1'b0; cell_read_enable = 1'b1; cell_index = 5'd5;
        cyc();
        idle();
        checks++;
        if (cell_rdata !== 16'h6666) begin
            errors++;
            $display("FAIL gate_read_noen: got %h expected 6666", cell_rdata);
        end
        cell_select = 1'b0; cell_enable = 1'b1; cell_write_enable = 1'b1;
        cell_index = 5'd6; cell_wdata = 16'hDEAD; cell_write_enable_bit = 16'hFFFF;
        cyc();
        cell_select = 1'b1; cell_enable = 1'b0;
        cyc();
        idle();
        do_read(5'd6);
        checks++;
        if (cell_rdata !== 16'h6666) begin
            errors++;
            $display("FAIL gate_write: got %h expected 6666", cell_rdata);
        end
    endtask

    task automatic test_boundary();
        do_write(5'd0, 16'h0000, 16'hFFFF);
        do_write(5'd16, 16'hBEEF, 16'hFFFF);
        do_read(5'd0);
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL oor_alias: got %h expected 0000", cell_rdata);
        end
        do_read(5'd5);
        do_read(5'd16);
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL oor_read16: got %h expected 0000", cell_rdata);
        end
        do_read(5'd5);
        do_read(5'd31);
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL oor_read31: got %h expected 0000", cell_rdata);
        end
        do_write(5'd4, 16'h1111, 16'hFFFF);
        do_read(5'd5);
        cell_select = 1'b1; cell_enable = 1'b1; cell_write_enable = 1'b1; cell_read_enable = 1'b1;
        cell_index = 5'd4; cell_wdata = 16'h4444; cell_write_enable_bit = 16'hFFFF;
        cyc();
        idle();
        checks++;
        if (cell_rdata !== 16'hFF34) begin
            errors++;
            $display("FAIL wr_rd_hold: got %h expected ff34", cell_rdata);
        end
        do_read(5'd4);
        checks++;
        if (cell_rdata !== 16'h4444) begin
            errors++;
            $display("FAIL wr_rd_mem: got %h expected 4444", cell_rdata);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        do_write(5'd7, 16'h7777, 16'hFFFF);
        do_read(5'd7);
        rst = 1'b1;
        cyc();
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_ready_rdata: got %h expected 0000", cell_rdata);
        end
`ifdef ERVP_SRAM_CELL_BANK_INIT_EN
        rst = 1'b0;
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cell_select = 1'b1; cell_enable = 1'b1; cell_write_enable = 1'b1;
        cell_index = 5'd2; cell_wdata = 16'hDEAD; cell_write_enable_bit = 16'hFFFF;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        idle();
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL resweep_length: got %0d cycles expected 16", n);
        end
        do_read(5'd2);
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL sweep_ignores_access: got %h expected 0000", cell_rdata);
        end
        do_read(5'd7);
        checks++;
        if (cell_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL resweep_zero: got %h expected 0000", cell_rdata);
        end
`else
        rst = 1'b0;
        checks++;
        if (init_done !== 1'b1 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_done: got busy=%b done=%b expected busy=0 done=1", init_busy, init_done);
        end
        do_read(5'd7);
        checks++;
        if (cell_rdata !== 16'h7777) begin
            errors++;
            $display("FAIL retain_after_reset: got %h expected 7777", cell_rdata);
        end
        n = 0;
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_gating();
        test_boundary();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
